// File: rtl/line_follower_pid.sv
// -----------------------------------------------------------------------------
// line_follower_pid
//   Clocked line follower: classifies the three LFA sensor samples with
//   hysteresis, runs an IDLE/FOLLOW/NODE_TURN/LOST state machine with
//   debounce, and closes a signed saturating PID loop that sets the motor
//   direction bits and per-wheel duty cycles for the PWM generators.
//
// Ports
//   clk_50M        system clock
//   reset          synchronous, active-high; overrides every other input
//   enable         run control; low forces IDLE with motors off
//   sample_valid   one-cycle strobe: left/middle/right carry a new sample
//   left/middle/right  ADC samples (ADC_W bits, unsigned)
//   m1_a, m1_b     left motor direction  (1,0 forward / 0,1 reverse)
//   m2_a, m2_b     right motor direction (same encoding)
//   dc1, dc2       left / right wheel duty, 0 .. 2^DUTY_W-1
//   node_count     nodes detected, wraps modulo 2^CNT_W
//   node_pulse     one-cycle pulse when a node is declared
//   state          IDLE=0, FOLLOW=1, NODE_TURN=2, LOST=3
// -----------------------------------------------------------------------------
module line_follower_pid #(
  parameter int ADC_W         = 12,
  parameter int DUTY_W        = 4,
  parameter int HI_TH         = 1200,
  parameter int LO_TH         = 700,
  parameter int BASE_DUTY     = 7,
  parameter int KP            = 1,
  parameter int KI            = 1,
  parameter int KD            = 2,
  parameter int I_LIM         = 4,
  parameter int NODE_DEBOUNCE = 2,
  parameter int LOST_SAMPLES  = 4,
  parameter int TURN_SAMPLES  = 8,
  parameter int TURN_FAST     = 10,
  parameter int TURN_SLOW     = 2,
  parameter int CNT_W         = 4
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  left,
  input  logic [ADC_W-1:0]  middle,
  input  logic [ADC_W-1:0]  right,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DUTY_W-1:0] dc1,
  output logic [DUTY_W-1:0] dc2,
  output logic [CNT_W-1:0]  node_count,
  output logic              node_pulse,
  output logic [2:0]        state
);

  // Arithmetic width for the PID terms: wide enough that nothing wraps
  // before the final saturation to the duty range.
  localparam int CW = DUTY_W + 8;

  localparam logic [ADC_W-1:0]     HI_T   = ADC_W'(HI_TH);
  localparam logic [ADC_W-1:0]     LO_T   = ADC_W'(LO_TH);
  localparam logic signed [CW-1:0] KP_S   = CW'(KP);
  localparam logic signed [CW-1:0] KI_S   = CW'(KI);
  localparam logic signed [CW-1:0] KD_S   = CW'(KD);
  localparam logic signed [CW-1:0] ILIM_S = CW'(I_LIM);
  localparam logic signed [CW-1:0] BASE_S = CW'(BASE_DUTY);
  localparam logic signed [CW-1:0] DMAX_S = CW'((1 << DUTY_W) - 1);
  localparam logic [DUTY_W-1:0]    FAST   = DUTY_W'(TURN_FAST);
  localparam logic [DUTY_W-1:0]    SLOW   = DUTY_W'(TURN_SLOW);
  localparam logic [DUTY_W-1:0]    BASE   = DUTY_W'(BASE_DUTY);

  // Drive patterns {m1_a, m1_b, m2_a, m2_b}
  localparam logic [3:0] DRV_OFF   = 4'b0000;
  localparam logic [3:0] DRV_FWD   = 4'b1010;
  localparam logic [3:0] DRV_RIGHT = 4'b1001;  // left fwd, right rev
  localparam logic [3:0] DRV_LEFT  = 4'b0110;  // left rev, right fwd

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOLLOW = 3'd1,
    S_TURN   = 3'd2,
    S_LOST   = 3'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sens_q, sens_d, sens_new;
  logic signed [3:0]       prev_err_q, prev_err_d, err;
  logic signed [CW-1:0]    integ_q, integ_d;
  logic                    last_dir_q, last_dir_d;  // 1 = +1 (line to the right)
  logic [7:0]              on_cnt_q, on_cnt_d, off_cnt_q, off_cnt_d;
  logic [7:0]              turn_cnt_q, turn_cnt_d;
  logic [CNT_W-1:0]        node_count_q, node_count_d;
  logic                    node_pulse_q, node_pulse_d;
  logic [3:0]              drive_q, drive_d;
  logic [DUTY_W-1:0]       dc1_q, dc1_d, dc2_q, dc2_d;
  logic                    do_follow, spin_dir, turn_done;

  logic signed [CW-1:0]    err_x, prev_x, integ_sum, integ_new, corr;
  logic [DUTY_W-1:0]       pid_dc1, pid_dc2;

  function automatic logic sense(input logic [ADC_W-1:0] s, input logic prev);
    if (s > HI_T) return 1'b1;
    if (s < LO_T) return 1'b0;
    return prev;  // dead band keeps the previous classification
  endfunction

  function automatic logic signed [3:0] line_err(input logic [2:0] p,
                                                 input logic signed [3:0] prev);
    case (p)
      3'b100:  return -4'sd2;
      3'b110:  return -4'sd1;
      3'b011:  return 4'sd1;
      3'b001:  return 4'sd2;
      3'b000:  return prev;  // no line seen: keep steering the same way
      default: return 4'sd0;  // 010, 101, 111
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [CW-1:0] v);
    if (v < 0) return '0;
    if (v > DMAX_S) return '1;
    return v[DUTY_W-1:0];
  endfunction

  // PID datapath for the sample being strobed in
  assign sens_new  = {sense(left,   sens_q[2]),
                      sense(middle, sens_q[1]),
                      sense(right,  sens_q[0])};
  assign err       = line_err(sens_new, prev_err_q);
  assign err_x     = {{(CW-4){err[3]}}, err};
  assign prev_x    = {{(CW-4){prev_err_q[3]}}, prev_err_q};
  assign integ_sum = integ_q + KI_S * err_x;
  assign integ_new = (integ_sum > ILIM_S)  ? ILIM_S  :
                     (integ_sum < -ILIM_S) ? -ILIM_S : integ_sum;
  assign corr      = KP_S * err_x + KD_S * (err_x - prev_x) + integ_new;
  assign pid_dc1   = sat_duty(BASE_S + corr);
  assign pid_dc2   = sat_duty(BASE_S - corr);
  assign turn_done = (int'(turn_cnt_q) + 1 >= TURN_SAMPLES) &&
                     (sens_new == 3'b010 || sens_new == 3'b011 || sens_new == 3'b110);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    sens_d       = sens_q;
    prev_err_d   = prev_err_q;
    integ_d      = integ_q;
    last_dir_d   = last_dir_q;
    on_cnt_d     = on_cnt_q;
    off_cnt_d    = off_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    node_count_d = node_count_q;
    node_pulse_d = 1'b0;
    drive_d      = drive_q;
    dc1_d        = dc1_q;
    dc2_d        = dc2_q;
    do_follow    = 1'b0;
    spin_dir     = last_dir_q;

    // enable low acts on every cycle, not only on strobes
    if (!enable) begin
      state_d    = S_IDLE;
      drive_d    = DRV_OFF;
      dc1_d      = '0;
      dc2_d      = '0;
      integ_d    = '0;
      prev_err_d = '0;
      on_cnt_d   = '0;
      off_cnt_d  = '0;
      turn_cnt_d = '0;
    end else if (sample_valid) begin
      sens_d = sens_new;
      case (state_q)
        S_IDLE, S_FOLLOW: do_follow = 1'b1;
        S_TURN: begin
          if (turn_done) begin
            do_follow = 1'b1;
          end else begin
            turn_cnt_d = sat_inc(turn_cnt_q);
            drive_d    = DRV_RIGHT;
            dc1_d      = FAST;
            dc2_d      = SLOW;
          end
        end
        S_LOST: begin
          if (|sens_new) begin
            // Reacquired: restart the loop from a clean state at base duty
            state_d    = S_FOLLOW;
            prev_err_d = '0;
            integ_d    = '0;
            drive_d    = DRV_FWD;
            dc1_d      = BASE;
            dc2_d      = BASE;
          end else begin
            drive_d = spin_dir ? DRV_RIGHT : DRV_LEFT;
            dc1_d   = spin_dir ? FAST : SLOW;
            dc2_d   = spin_dir ? SLOW : FAST;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (do_follow) begin
        state_d    = S_FOLLOW;
        drive_d    = DRV_FWD;
        dc1_d      = pid_dc1;
        dc2_d      = pid_dc2;
        prev_err_d = err;
        integ_d    = integ_new;
        if (err != 4'sd0) last_dir_d = ~err[3];
        spin_dir   = last_dir_d;

        if (sens_new == 3'b111) begin
          off_cnt_d = '0;
          on_cnt_d  = sat_inc(on_cnt_q);
          if (int'(on_cnt_q) + 1 >= NODE_DEBOUNCE) begin
            state_d      = S_TURN;
            on_cnt_d     = '0;
            turn_cnt_d   = '0;
            node_count_d = node_count_q + CNT_W'(1);
            node_pulse_d = 1'b1;
            integ_d      = '0;
            drive_d      = DRV_RIGHT;
            dc1_d        = FAST;
            dc2_d        = SLOW;
          end
        end else if (sens_new == 3'b000) begin
          on_cnt_d  = '0;
          off_cnt_d = sat_inc(off_cnt_q);
          if (int'(off_cnt_q) + 1 >= LOST_SAMPLES) begin
            state_d   = S_LOST;
            off_cnt_d = '0;
            integ_d   = '0;
            drive_d   = spin_dir ? DRV_RIGHT : DRV_LEFT;
            dc1_d     = spin_dir ? FAST : SLOW;
            dc2_d     = spin_dir ? SLOW : FAST;
          end
        end else begin
          on_cnt_d  = '0;
          off_cnt_d = '0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sens_q       <= '0;
      prev_err_q   <= '0;
      integ_q      <= '0;
      last_dir_q   <= 1'b1;
      on_cnt_q     <= '0;
      off_cnt_q    <= '0;
      turn_cnt_q   <= '0;
      node_count_q <= '0;
      node_pulse_q <= 1'b0;
      drive_q      <= DRV_OFF;
      dc1_q        <= '0;
      dc2_q        <= '0;
    end else begin
      state_q      <= state_d;
      sens_q       <= sens_d;
      prev_err_q   <= prev_err_d;
      integ_q      <= integ_d;
      last_dir_q   <= last_dir_d;
      on_cnt_q     <= on_cnt_d;
      off_cnt_q    <= off_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      node_count_q <= node_count_d;
      node_pulse_q <= node_pulse_d;
      drive_q      <= drive_d;
      dc1_q        <= dc1_d;
      dc2_q        <= dc2_d;
    end
  end

  assign {m1_a, m1_b, m2_a, m2_b} = drive_q;
  assign dc1        = dc1_q;
  assign dc2        = dc2_q;
  assign node_count = node_count_q;
  assign node_pulse = node_pulse_q;
  assign state      = state_q;

endmodule
